// File: rtl/addr_latch_bank.sv
// Multi-bank 74LS259-style addressable output latch with optional one-shot pulse bits.
// Each bit is either a plain latch or a self-clearing pulse counter, chosen by PULSE_MASK.
module addr_latch_bank #(
  parameter int ADDR_W = 3,
  parameter int BANKS = 2,
  parameter int BSEL_W = 1,
  parameter logic [BANKS*(2**ADDR_W)-1:0] RESET_VAL = '0,
  parameter logic [BANKS*(2**ADDR_W)-1:0] PULSE_MASK = '0,
  parameter int PULSE_W = 8,
  parameter int PULSE_LEN = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_n,
  input  logic                            clr_n,
  input  logic [BSEL_W-1:0]               bank_sel,
  input  logic [ADDR_W-1:0]               addr,
  input  logic                            data,
  output logic [BANKS*(2**ADDR_W)-1:0]    q,
  output logic                            pulse_busy
);

  localparam int NB = 2**ADDR_W;
  localparam int NW = BANKS * NB;

  logic [NW-1:0] w_q;
  logic [NW-1:0] w_busy;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    // A bank_sel value with no matching bank selects nothing, so the cycle is a no-op.
    logic w_sel;
    assign w_sel = (bank_sel == BSEL_W'(b));

    for (genvar i = 0; i < NB; i++) begin : g_bit
      localparam int IDX = b * NB + i;
      logic w_hit;
      logic w_wr;
      logic w_clr;

      assign w_hit = w_sel && (addr == ADDR_W'(i));
      assign w_wr  = w_hit && !wr_n;
      // Clear mode clears every bit; demux mode clears all bits except the addressed one.
      assign w_clr = w_sel && !clr_n && !w_wr;

      if (PULSE_MASK[IDX]) begin : g_pulse
        logic [PULSE_W-1:0] r_cnt;

        always_ff @(posedge clk) begin
          if (reset) begin
            r_cnt <= '0;
          end else if (w_wr) begin
            r_cnt <= data ? PULSE_W'(PULSE_LEN) : '0;
          end else if (w_clr) begin
            r_cnt <= '0;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PULSE_W'(1);
          end
        end

        assign w_q[IDX]    = (r_cnt != '0);
        assign w_busy[IDX] = (r_cnt != '0);
      end else begin : g_latch
        logic r_bit;

        always_ff @(posedge clk) begin
          if (reset) begin
            r_bit <= RESET_VAL[IDX];
          end else if (w_wr) begin
            r_bit <= data;
          end else if (w_clr) begin
            r_bit <= 1'b0;
          end
        end

        assign w_q[IDX]    = r_bit;
        assign w_busy[IDX] = 1'b0;
      end
    end
  end

  assign q          = w_q;
  assign pulse_busy = |w_busy;

endmodule

// File: tb/tb_addr_latch_bank.sv
// Bench for addr_latch_bank: three instances (plain latch, pulse, three-bank) on shared stimulus,
// each phase checks one instance against expected {pulse_busy, q} values from a queue.
module tb_addr_latch_bank;

  logic       clk;
  logic       reset;
  logic       wr_n;
  logic       clr_n;
  logic [1:0] bank_sel;
  logic [2:0] addr;
  logic       data;

  logic [15:0] q0;
  logic        busy0;
  logic [15:0] q1;
  logic        busy1;
  logic [23:0] q2;
  logic        busy2;

  int which;
  int checks;
  int errors;
  logic [24:0] exp_q[$];

  typedef struct {
    logic        rst;
    logic        wr_n;
    logic        clr_n;
    logic [1:0]  bs;
    logic [2:0]  a;
    logic        d;
    logic [24:0] exp;
  } vec_t;

  vec_t vecs[14];

  addr_latch_bank #(
    .ADDR_W(3), .BANKS(2), .BSEL_W(1),
    .RESET_VAL(16'h00A5), .PULSE_MASK(16'h0000),
    .PULSE_W(8), .PULSE_LEN(16)
  ) dut0 (
    .clk(clk), .reset(reset), .wr_n(wr_n), .clr_n(clr_n),
    .bank_sel(bank_sel[0:0]), .addr(addr), .data(data),
    .q(q0), .pulse_busy(busy0)
  );

  addr_latch_bank #(
    .ADDR_W(3), .BANKS(2), .BSEL_W(1),
    .RESET_VAL(16'h0000), .PULSE_MASK(16'h0001),
    .PULSE_W(8), .PULSE_LEN(16)
  ) dut1 (
    .clk(clk), .reset(reset), .wr_n(wr_n), .clr_n(clr_n),
    .bank_sel(bank_sel[0:0]), .addr(addr), .data(data),
    .q(q1), .pulse_busy(busy1)
  );

  addr_latch_bank #(
    .ADDR_W(3), .BANKS(3), .BSEL_W(2),
    .RESET_VAL(24'h3C00A5), .PULSE_MASK(24'h000000),
    .PULSE_W(8), .PULSE_LEN(16)
  ) dut2 (
    .clk(clk), .reset(reset), .wr_n(wr_n), .clr_n(clr_n),
    .bank_sel(bank_sel), .addr(addr), .data(data),
    .q(q2), .pulse_busy(busy2)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [24:0] get_out();
    case (which)
      0:       return {busy0, 8'h00, q0};
      1:       return {busy1, 8'h00, q1};
      default: return {busy2, q2};
    endcase
  endfunction

  task automatic check(input string name);
    logic [24:0] got;
    logic [24:0] e;
    got = get_out();
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s (dut%0d): got busy/q=%h expected %h", name, which, got, e);
    end
  endtask

  task automatic apply(input logic rst, input logic w, input logic c, input logic [1:0] bs,
                       input logic [2:0] a, input logic d, input logic [24:0] exp,
                       input string name);
    reset = rst;
    wr_n = w;
    clr_n = c;
    bank_sel = bs;
    addr = a;
    data = d;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    check(name);
  endtask

  task automatic hold(input logic [24:0] exp, input string name);
    apply(1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, exp, name);
  endtask

  task automatic pwrite(input logic d, input logic [24:0] exp, input string name);
    apply(1'b0, 1'b0, 1'b1, 2'd0, 3'd0, d, exp, name);
  endtask

  initial begin
    logic [15:0] m;
    logic [1:0]  rbs;
    logic [2:0]  ra;
    logic        rd;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    wr_n = 1'b1;
    clr_n = 1'b1;
    bank_sel = 2'd0;
    addr = 3'd0;
    data = 1'b0;

    // Plain latch instance: reset, latch, clear, demux, level-sensitive rewrite.
    which = 0;
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h00A5};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h00A5};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 25'h00A5};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 2'd1, 3'd3, 1'b1, 25'h08A5};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd1, 3'd3, 1'b0, 25'h00A5};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 25'h0000};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd6, 1'b1, 25'h0040};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 3'd7, 1'b1, 25'h8040};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b1, 25'h0140};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b1, 25'h0141};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 25'h0140};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 2'd1, 3'd2, 1'b1, 25'h0040};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h0040};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'd7, 1'b1, 25'h00C0};
    for (int k = 0; k < 14; k++) begin
      apply(vecs[k].rst, vecs[k].wr_n, vecs[k].clr_n, vecs[k].bs, vecs[k].a, vecs[k].d,
            vecs[k].exp, $sformatf("vec%0d", k));
    end

    // Random addressable writes against a bit-array model.
    apply(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h00A5, "rand_reset");
    m = 16'h00A5;
    for (int k = 0; k < 20; k++) begin
      rbs = 2'($urandom_range(0, 1));
      ra  = 3'($urandom_range(0, 7));
      rd  = 1'($urandom_range(0, 1));
      m[{rbs[0], ra}] = rd;
      apply(1'b0, 1'b0, 1'b1, rbs, ra, rd, {9'b0, m}, $sformatf("rand_wr%0d", k));
    end

    // Pulse instance: bit 0 is a 16-clock one-shot.
    which = 1;
    apply(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h0, "p_reset");
    hold(25'h0, "p_idle");
    pwrite(1'b1, 25'h1000001, "p_single_start");
    for (int c = 1; c < 16; c++) hold(25'h1000001, $sformatf("p_single_hi%0d", c));
    hold(25'h0, "p_single_end");
    hold(25'h0, "p_single_stays_low");

    pwrite(1'b1, 25'h1000001, "p_retrig_start");
    for (int c = 1; c < 10; c++) hold(25'h1000001, $sformatf("p_retrig_a%0d", c));
    pwrite(1'b1, 25'h1000001, "p_retrig_reload");
    for (int c = 11; c < 26; c++) hold(25'h1000001, $sformatf("p_retrig_b%0d", c));
    hold(25'h0, "p_retrig_end");

    pwrite(1'b1, 25'h1000001, "p_w0_start");
    for (int c = 1; c < 5; c++) hold(25'h1000001, $sformatf("p_w0_hi%0d", c));
    pwrite(1'b0, 25'h0, "p_w0_drop");
    hold(25'h0, "p_w0_low");

    for (int c = 0; c < 3; c++) pwrite(1'b1, 25'h1000001, $sformatf("p_held%0d", c));
    for (int c = 3; c < 18; c++) hold(25'h1000001, $sformatf("p_held_hi%0d", c));
    hold(25'h0, "p_held_end");

    pwrite(1'b1, 25'h1000001, "p_clr_start");
    hold(25'h1000001, "p_clr_active");
    apply(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 25'h0, "p_clr_bank0");
    hold(25'h0, "p_clr_after");

    pwrite(1'b1, 25'h1000001, "p_dmx_start");
    apply(1'b0, 1'b0, 1'b0, 2'd0, 3'd5, 1'b1, 25'h0000020, "p_demux_other");
    apply(1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 25'h0, "p_demux_cleanup");

    pwrite(1'b1, 25'h1000001, "p_b1_start");
    apply(1'b0, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 25'h1000001, "p_clr_bank1_keeps");
    apply(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h0, "p_reset_mid");
    for (int c = 0; c < 3; c++) hold(25'h0, $sformatf("p_after_reset%0d", c));
    apply(1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 1'b1, 25'h0, "p_reset_over_write");
    hold(25'h0, "p_reset_over_write_after");

    // Three-bank instance: bank_sel=3 is out of range.
    which = 2;
    apply(1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 25'h3C00A5, "oor_reset");
    apply(1'b0, 1'b0, 1'b1, 2'd3, 3'd3, 1'b1, 25'h3C00A5, "oor_write");
    apply(1'b0, 1'b1, 1'b0, 2'd3, 3'd0, 1'b0, 25'h3C00A5, "oor_clear");
    apply(1'b0, 1'b0, 1'b0, 2'd3, 3'd1, 1'b1, 25'h3C00A5, "oor_demux");
    apply(1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b1, 25'h3D00A5, "b2_write");
    apply(1'b0, 1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 25'h0000A5, "b2_clear");
    apply(1'b0, 1'b0, 1'b0, 2'd1, 3'd4, 1'b1, 25'h0010A5, "b1_demux");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_latch_bank.md
Name: addr_latch_bank

Overview:
Parametrised multi-bank addressable output latch for CPU-driven discrete outputs: LEDs, sound enables, counter-increment strobes, player/flip selects. Each bank behaves as a 74LS259 with all four modes: hold, addressable latch, demultiplex and clear. Selected bits can also be one-shot pulse outputs that self-clear after a programmable number of clocks, for coin counters and strobes. It sits on the CPU write bus behind the address decoder and replaces single-bank, single-mode output latches.

Parameters:
ADDR_W, 3, bit-address width; bits per bank NB = 2**ADDR_W
BANKS, 2, number of independent banks (1..8)
BSEL_W, 1, bank-select width; must satisfy 2**BSEL_W >= BANKS
RESET_VAL, 0, BANKS*NB-bit reset image; bank b bit i at index b*NB+i
PULSE_MASK, 0, BANKS*NB-bit mask; 1 = bit is a one-shot pulse output
PULSE_W, 8, pulse counter width
PULSE_LEN, 16, pulse length in clocks (1..2**PULSE_W-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
wr_n  in  1  write strobe, active low, level-sampled every clk
clr_n  in  1  clear strobe, active low, level-sampled every clk
bank_sel  in  BSEL_W  bank addressed by wr_n/clr_n
addr  in  ADDR_W  bit address within bank
data  in  1  bit value written (CPU data bit)
q  out  BANKS*NB  latched outputs, bank b bit i at q[b*NB+i]
pulse_busy  out  1  OR of all active pulse counters

Behaviour:
- One clock, clk. Reset is synchronous and active-high, named reset.
- Reset: q = RESET_VAL except PULSE_MASK bits, which reset to 0. All pulse counters reset to 0 and pulse_busy = 0. Reset overrides every strobe in the same cycle.
- All state is registered. A strobe sampled at clk edge k is visible on q after edge k. No combinational path from inputs to q.
- Only bank bank_sel is affected. If bank_sel >= BANKS the cycle is a no-op. Other banks always hold.
- Mode table for the selected bank, using latch bits (non-pulse):
  - wr_n=1, clr_n=1: hold.
  - wr_n=0, clr_n=1: addressable latch. Bit addr <= data; other bits hold.
  - wr_n=1, clr_n=0: clear. All NB bits <= 0.
  - wr_n=0, clr_n=0: demux. Bit addr <= data; all other bits <= 0.
- Strobes are level-sensitive. Holding wr_n low for several clocks rewrites the bit each clock, with the last value winning. No edge detection.
- Pulse bits (PULSE_MASK=1), each with its own PULSE_W-bit counter cnt:
  - Output q bit = (cnt != 0).
  - Write of 1 to the bit loads cnt = PULSE_LEN. A write while active restarts the count (retrigger).
  - Write of 0 to the bit loads cnt = 0; output drops after the edge.
  - Clear mode, or demux mode where the bit is not addressed, loads cnt = 0.
  - Otherwise, if cnt != 0, cnt decrements by 1 per clock. It saturates at 0, with no wrap.
  - A write of 1 held for W clocks gives an output high for W + PULSE_LEN - 1 clocks after the first edge.
  - A load and a decrement in the same cycle: the load wins.
- pulse_busy is registered-equivalent: the OR of (cnt != 0) over all pulse bits.
- Reset asserted mid-pulse drops the pulse at the next edge. There is no residual count.

Test Plan:
- Reset with RESET_VAL=16'h00A5, PULSE_MASK=0: release reset -> q=16'h00A5. Assert reset with wr_n=0, addr=0, data=0 -> q stays 16'h00A5.
- Addressable latch: bank 1, addr=3, data=1, wr_n low 1 clk -> q=16'h08A5 after that edge. Repeat with data=0 -> q=16'h00A5. Bank 0 is unchanged throughout.
- Clear and demux on bank 0 holding 8'hA5: clr_n=0 -> bank0=8'h00. Then wr_n=0 and clr_n=0, addr=6, data=1 -> bank0=8'h40. Bank 1 is untouched.
- Pulse with PULSE_MASK bit 0 set and PULSE_LEN=16: write 1 for 1 clk -> q[0]=1 for exactly 16 clocks and pulse_busy mirrors it. Rewrite 1 at clock 10 -> high until clock 26. Write 0 at clock 5 -> low at clock 6.
- Pulse vs clear: clear bank 0 while the pulse is active -> q[0]=0 and pulse_busy=0 next edge. Assert reset mid-pulse -> same result, and the pulse is not re-triggered after reset.
- Out-of-range bank with BANKS=3, BSEL_W=2: bank_sel=3 with wr_n=0 or clr_n=0 -> q unchanged.
